// File: rtl/gate_io_pkg.sv
// Shared definitions for the gate input conditioning stage.
// Holds the debounce FSM state encoding and the default debounce length,
// so the channel and the top level agree on both.
package gate_io_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } deb_state_t;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000;

endpackage : gate_io_pkg

// File: rtl/debounce_channel.sv
// One input conditioning channel: a metastability synchroniser followed by a
// debounce FSM. A new synchronised level is accepted only after it has differed
// from the current output for DEBOUNCE_CYCLES consecutive cycles. Any cycle
// where the level matches the output again abandons the pending change.
module debounce_channel
   import gate_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = 2,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic changed,
   output logic idle
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   deb_state_t             state;
   logic [CNT_W-1:0]       cnt;

   // Shift the raw asynchronous level through the synchroniser chain; only the
   // last flop is trusted by the rest of the logic.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

   // Debounce FSM: IDLE waits for the synced level to disagree with the output,
   // COUNT counts consecutive disagreeing cycles. The first disagreeing cycle
   // already counts as one, so the output flips on disagreement number
   // DEBOUNCE_CYCLES together with a single-cycle change strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         level   <= 1'b0;
         changed <= 1'b0;
      end else begin
         changed <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (synced != level) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     level   <= synced;
                     changed <= 1'b1;
                     cnt     <= '0;
                  end else begin
                     state <= ST_COUNT;
                     cnt   <= CNT_ONE;
                  end
               end else begin
                  cnt <= '0;
               end
            end
            ST_COUNT: begin
               if (synced == level) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else if (cnt >= CNT_LAST) begin
                  level   <= synced;
                  changed <= 1'b1;
                  state   <= ST_IDLE;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign idle = (state == ST_IDLE);

endmodule : debounce_channel

// File: rtl/gate_input_debounce.sv
// Input conditioner in front of the two-input gate stage. Two independent
// debounce channels turn bouncy switch levels into clean operands a and b,
// each with a one-cycle change strobe, plus a flag showing that neither
// channel has a change pending.
module gate_input_debounce
   import gate_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = 2,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_a_raw,
   input  logic sw_b_raw,
   output logic a,
   output logic b,
   output logic a_changed,
   output logic b_changed,
   output logic stable
);

   logic idle_a;
   logic idle_b;

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .CNT_W           (CNT_W)
   ) u_chan_a (
      .clk     (clk),
      .rst     (rst),
      .raw     (sw_a_raw),
      .level   (a),
      .changed (a_changed),
      .idle    (idle_a)
   );

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .CNT_W           (CNT_W)
   ) u_chan_b (
      .clk     (clk),
      .rst     (rst),
      .raw     (sw_b_raw),
      .level   (b),
      .changed (b_changed),
      .idle    (idle_b)
   );

   assign stable = idle_a & idle_b;

endmodule : gate_input_debounce

// File: tb/tb_gate_input_debounce.sv
// Directed bench for gate_input_debounce with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Inputs change on the falling edge and outputs are checked on the next falling
// edge, so each stimulus step covers exactly one rising edge.
module tb_gate_input_debounce;

   typedef struct {
      logic       rst;
      logic       sa;
      logic       sb;
      logic [4:0] exp;
      string      name;
   } vec_t;

   logic clk;
   logic rst;
   logic sw_a_raw;
   logic sw_b_raw;
   logic a;
   logic b;
   logic a_changed;
   logic b_changed;
   logic stable;

   int num_checks;
   int num_errors;

   vec_t vecs[$];

   gate_input_debounce #(
      .DEBOUNCE_CYCLES (4),
      .SYNC_STAGES     (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sw_a_raw  (sw_a_raw),
      .sw_b_raw  (sw_b_raw),
      .a         (a),
      .b         (b),
      .a_changed (a_changed),
      .b_changed (b_changed),
      .stable    (stable)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(logic r, logic sa, logic sb, logic [4:0] e, string n);
      vec_t v;
      v.rst  = r;
      v.sa   = sa;
      v.sb   = sb;
      v.exp  = e;
      v.name = n;
      return v;
   endfunction

   function automatic logic st_exp(int k);
      return !(k >= 3 && k <= 5);
   endfunction

   task automatic applyStimulus(input logic r, input logic sa, input logic sb);
      rst      = r;
      sw_a_raw = sa;
      sw_b_raw = sb;
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [4:0] exp, input logic [4:0] mask);
      logic [4:0] act;
      act = {a, b, a_changed, b_changed, stable};
      num_checks++;
      if ((act & mask) !== (exp & mask)) begin
         num_errors++;
         $display("[TB] FAIL %s: got {a,b,ac,bc,st}=%b expected %b (mask %b)", name, act, exp, mask);
      end
   endtask

   initial begin
      num_checks = 0;
      num_errors = 0;
      rst        = 1'b1;
      sw_a_raw   = 1'b0;
      sw_b_raw   = 1'b0;

      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(1'b1, 1'b0, 1'b0, 5'b00001, $sformatf("reset_%0d", i)));
      for (int i = 0; i < 20; i++)
         vecs.push_back(mk(1'b0, 1'b0, 1'b0, 5'b00001, $sformatf("idle_%0d", i)));
      for (int k = 1; k <= 8; k++)
         vecs.push_back(mk(1'b0, 1'b1, 1'b0,
                           {logic'(k >= 6), 1'b0, logic'(k == 6), 1'b0, st_exp(k)},
                           $sformatf("a_rise_e%0d", k)));

      $display("[TB] table vectors: %0d", vecs.size());
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].sa, vecs[i].sb);
         checkOutput(vecs[i].name, vecs[i].exp, 5'b11111);
      end

      $display("[TB] short b glitch");
      for (int k = 1; k <= 12; k++) begin
         applyStimulus(1'b0, 1'b1, logic'(k <= 3));
         checkOutput($sformatf("b_glitch_e%0d", k), {1'b1, 1'b0, 1'b0, 1'b0, st_exp(k)}, 5'b11111);
      end

      $display("[TB] b toggling then held");
      begin
         logic [9:0] pat;
         pat = 10'b0000110011;
         for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b0, 1'b1, pat[k-1]);
            checkOutput($sformatf("b_toggle_e%0d", k), 5'b10000, 5'b11110);
         end
      end
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b1);
         checkOutput($sformatf("b_rise_e%0d", k),
                     {1'b1, logic'(k >= 6), 1'b0, logic'(k == 6), st_exp(k)}, 5'b11111);
      end
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
         checkOutput($sformatf("b_fall_e%0d", k),
                     {1'b1, logic'(k < 6), 1'b0, logic'(k == 6), st_exp(k)}, 5'b11111);
      end

      $display("[TB] simultaneous rise");
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("a_fall_e%0d", k),
                     {logic'(k < 6), 1'b0, logic'(k == 6), 1'b0, st_exp(k)}, 5'b11111);
      end
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b1);
         checkOutput($sformatf("both_rise_e%0d", k),
                     {logic'(k >= 6), logic'(k >= 6), logic'(k == 6), logic'(k == 6), st_exp(k)},
                     5'b11111);
      end

      $display("[TB] reset during count");
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         checkOutput($sformatf("a_fall2_e%0d", k),
                     {logic'(k < 6), 1'b1, logic'(k == 6), 1'b0, st_exp(k)}, 5'b11111);
      end
      for (int k = 1; k <= 12; k++) begin
         int j;
         logic [4:0] e;
         j = k - 4;
         if (k <= 3)
            e = {1'b0, 1'b1, 1'b0, 1'b0, logic'(k < 3)};
         else if (k == 4)
            e = 5'b00001;
         else
            e = {logic'(j >= 6), logic'(j >= 6), logic'(j == 6), logic'(j == 6), st_exp(j)};
         applyStimulus(logic'(k == 4), 1'b1, 1'b1);
         checkOutput($sformatf("rst_mid_e%0d", k), e, 5'b11111);
      end

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule : tb_gate_input_debounce
